// File: rtl/spike_decoder_if.sv
// rtl/spike_decoder_if.sv - decoded rate/ISI results plus the rate consumer's ready.
interface spike_decoder_if #(
  parameter int CNT_W = 5,
  parameter int ISI_W = 8
);
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ready;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             overflow;

  modport master (
    output rate, rate_valid, isi, isi_valid, overflow,
    input  rate_ready
  );

  modport slave (
    input  rate, rate_valid, isi, isi_valid, overflow,
    output rate_ready
  );
endinterface

// File: rtl/spike_decoder.sv
// rtl/spike_decoder.sv - spike train to windowed firing rate and inter-spike interval.
module spike_decoder #(
  parameter int WINDOW_LOG2 = 4,
  parameter int CNT_W       = 5,
  parameter int ISI_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              spike,
  spike_decoder_if.master   dout
);

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} isi_state_t;

  logic [WINDOW_LOG2-1:0] wc;
  logic [CNT_W-1:0]       sc;
  logic [CNT_W-1:0]       sc_inc;
  logic [CNT_W-1:0]       rate_q;
  logic                   rate_valid_q;
  logic                   overflow_q;
  logic                   window_end;

  isi_state_t             state_q, state_d;
  logic [ISI_W-1:0]       t_q, t_d;
  logic [ISI_W-1:0]       isi_q;
  logic                   isi_valid_q;
  logic                   isi_hit;

  // Count including this cycle's spike, held at full scale.
  assign sc_inc     = (spike && sc != '1) ? sc + CNT_W'(1) : sc;
  assign window_end = enable && (wc == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wc           <= '0;
      sc           <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (enable) begin
        wc <= wc + WINDOW_LOG2'(1);
        sc <= window_end ? '0 : sc_inc;
      end
      if (window_end) begin
        rate_q       <= sc_inc;
        rate_valid_q <= 1'b1;
        if (rate_valid_q && !dout.rate_ready)
          overflow_q <= 1'b1;
      end else if (rate_valid_q && dout.rate_ready) begin
        rate_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      isi_valid_q <= isi_hit;
      if (isi_hit)
        isi_q <= t_q;
    end
  end

  // A disabled cycle breaks the interval, so the next spike restarts timing.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    isi_hit = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (spike) begin
            state_d = MEASURE;
            t_d     = ISI_W'(1);
          end
        end
        MEASURE: begin
          if (spike) begin
            isi_hit = 1'b1;
            t_d     = ISI_W'(1);
          end else if (t_q == '1) begin
            state_d = TIMEOUT;
          end else begin
            t_d = t_q + ISI_W'(1);
          end
        end
        TIMEOUT: begin
          if (spike) begin
            state_d = MEASURE;
            t_d     = ISI_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dout.rate       = rate_q;
  assign dout.rate_valid = rate_valid_q;
  assign dout.overflow   = overflow_q;
  assign dout.isi        = isi_q;
  assign dout.isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_decoder.sv
// tb/tb_spike_decoder.sv - directed bench for spike_decoder with a timestamp-based reference model.
module tb_spike_decoder;
  localparam int WL      = 4;
  localparam int CW      = 5;
  localparam int IW      = 8;
  localparam int WIN     = 16;
  localparam int ISI_MAX = 255;
  localparam int CNT_MAX = 31;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic spike = 1'b0;

  spike_decoder_if #(.CNT_W(CW), .ISI_W(IW)) bus ();

  spike_decoder #(.WINDOW_LOG2(WL), .CNT_W(CW), .ISI_W(IW)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .spike  (spike),
    .dout   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  // Reference: window position, running count, and the enabled-time stamp of the last spike.
  int m_win, m_cnt, m_rate, m_isi, m_last, m_time;
  bit m_rv, m_iv, m_ovf, m_xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_win = 0; m_cnt = 0; m_rate = 0; m_rv = 0; m_ovf = 0;
      m_isi = 0; m_iv = 0; m_last = -1; m_time = 0;
    end else begin
      m_xfer = m_rv && bus.rate_ready;
      m_iv   = 0;
      if (enable) begin
        if (spike) begin
          m_cnt++;
          if (m_last >= 0 && (m_time - m_last) <= ISI_MAX) begin
            m_isi = m_time - m_last;
            m_iv  = 1;
          end
          m_last = m_time;
        end
        m_time++;
        if (m_win == WIN - 1) begin
          if (m_rv && !bus.rate_ready) m_ovf = 1;
          m_rate = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
          m_rv   = 1;
          m_cnt  = 0;
          m_win  = 0;
        end else begin
          m_win++;
          if (m_xfer) m_rv = 0;
        end
      end else begin
        m_last = -1;
        if (m_xfer) m_rv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("rate", bus.rate, m_rate);
      chk("rate_valid", bus.rate_valid, m_rv);
      chk("overflow", bus.overflow, m_ovf);
      chk("isi_valid", bus.isi_valid, m_iv);
      chk("isi", bus.isi, m_isi);
    end
  end

  task automatic step(input bit sp);
    spike = sp;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit ready);
    reset = 1'b1; enable = 1'b0; spike = 1'b0; bus.rate_ready = 1'b0;
    @(negedge clk);
    chk("reset_rate", bus.rate, 0);
    chk("reset_rv", bus.rate_valid, 0);
    chk("reset_ovf", bus.overflow, 0);
    chk("reset_iv", bus.isi_valid, 0);
    reset = 1'b0; enable = 1'b1; bus.rate_ready = ready;
  endtask

  initial begin
    bus.rate_ready = 1'b0;
    @(negedge clk);
    armed = 1'b1;

    // 1: spike every cycle
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      if (i == 0)  chk("s1_first_iv", bus.isi_valid, 0);
      if (i == 1)  begin chk("s1_iv", bus.isi_valid, 1); chk("s1_isi", bus.isi, 1); end
      if (i == 14) chk("s1_rv_early", bus.rate_valid, 0);
      if (i == 15) begin chk("s1_rv", bus.rate_valid, 1); chk("s1_rate", bus.rate, 16); end
      if (i == 16) chk("s1_rv_drop", bus.rate_valid, 0);
      if (i == 31) chk("s1_rate2", bus.rate, 16);
    end

    // 2: spike every 4th cycle
    do_reset(1'b1);
    for (int i = 0; i < 48; i++) begin
      step(i % 4 == 0);
      if (i == 0)  chk("s2_first_iv", bus.isi_valid, 0);
      if (i == 4)  begin chk("s2_iv", bus.isi_valid, 1); chk("s2_isi", bus.isi, 4); end
      if (i == 15) begin chk("s2_rv", bus.rate_valid, 1); chk("s2_rate", bus.rate, 4); end
    end

    // 3: consumer stalled, then one accept
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      step((i % 16 == 1) || (i % 16 == 5) || (i % 16 == 9));
      if (i == 15) begin chk("s3_ovf_first", bus.overflow, 0); chk("s3_rate1", bus.rate, 3); end
      if (i == 31) begin
        chk("s3_ovf", bus.overflow, 1); chk("s3_rv", bus.rate_valid, 1); chk("s3_rate2", bus.rate, 3);
      end
    end
    bus.rate_ready = 1'b1;
    step(1'b0);
    chk("s3_drain_rv", bus.rate_valid, 0);
    chk("s3_drain_ovf", bus.overflow, 1);
    bus.rate_ready = 1'b0;
    step(1'b0);

    // 4: timeout then short interval
    do_reset(1'b1);
    for (int i = 0; i < 306; i++) begin
      step(i == 0 || i == 300 || i == 305);
      if (i == 300) chk("s4_timeout_iv", bus.isi_valid, 0);
      if (i == 305) begin chk("s4_iv", bus.isi_valid, 1); chk("s4_isi", bus.isi, 5); end
    end

    // 5: reset mid-window
    do_reset(1'b1);
    for (int i = 0; i < 7; i++) step(i < 5);
    reset = 1'b1;
    step(1'b0);
    chk("s5_rate0", bus.rate, 0);
    chk("s5_isi0", bus.isi, 0);
    chk("s5_iv0", bus.isi_valid, 0);
    chk("s5_rv0", bus.rate_valid, 0);
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(i == 2 || i == 9);
      if (i == 2)  chk("s5_first_iv", bus.isi_valid, 0);
      if (i == 9)  chk("s5_isi", bus.isi, 7);
      if (i == 14) chk("s5_rv_early", bus.rate_valid, 0);
      if (i == 15) begin chk("s5_rv", bus.rate_valid, 1); chk("s5_rate", bus.rate, 2); end
    end

    // 6: disabled gap with spikes held high
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(i == 2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    enable = 1'b1;
    for (int i = 15; i < 28; i++) begin
      step(i == 15 || i == 20);
      if (i == 15) chk("s6_first_iv", bus.isi_valid, 0);
      if (i == 20) begin chk("s6_iv", bus.isi_valid, 1); chk("s6_isi", bus.isi, 5); end
      if (i == 24) chk("s6_rv_early", bus.rate_valid, 0);
      if (i == 25) begin chk("s6_rv", bus.rate_valid, 1); chk("s6_rate", bus.rate, 3); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
